// File: rtl/reg_file.sv
// reg_file: architectural register file with per-register rename tags (busy + ROB tag).
// Optional macro REGFILE_BYPASS_EN forwards a matching commit onto the read ports in the same cycle.
module reg_file #(
  parameter int REG_ADDR_WIDTH = 5,
  parameter int Q_WIDTH        = 4
) (
  input  logic                      clk_in,
  input  logic                      rst_in,
  input  logic                      rdy_in,
  input  logic                      control_hazard,
  input  logic                      has_issue,
  input  logic [REG_ADDR_WIDTH-1:0] rd_addr,
  input  logic                      rename_en,
  input  logic [Q_WIDTH-1:0]        rob_tail,
  input  logic                      commit_modify_regfile,
  input  logic [REG_ADDR_WIDTH-1:0] commit_reg_addr,
  input  logic [Q_WIDTH-1:0]        Commit_Q,
  input  logic [31:0]               Commit_V,
  input  logic [REG_ADDR_WIDTH-1:0] rs1_addr,
  input  logic [REG_ADDR_WIDTH-1:0] rs2_addr,
  output logic                      busy1,
  output logic                      busy2,
  output logic [Q_WIDTH-1:0]        Q1,
  output logic [Q_WIDTH-1:0]        Q2,
  output logic [31:0]               V1,
  output logic [31:0]               V2
);
  localparam int NUM_REGS = 1 << REG_ADDR_WIDTH;

  logic [31:0]         value_q [NUM_REGS];
  logic [NUM_REGS-1:0] busy_q;
  logic [Q_WIDTH-1:0]  tag_q   [NUM_REGS];

  logic rename_hit;
  logic commit_hit;
  logic commit_match;
  logic fwd1;
  logic fwd2;

  // A commit only releases the register when no younger rename has replaced its tag.
  always_comb begin
    rename_hit   = has_issue && rename_en && (rd_addr != '0);
    commit_hit   = commit_modify_regfile && (commit_reg_addr != '0);
    commit_match = commit_hit && (tag_q[commit_reg_addr] == Commit_Q);
  end

  // rdy_in is a global stall: while low, every register holds; reset still wins.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      busy_q <= '0;
      for (int i = 0; i < NUM_REGS; i++) begin
        value_q[i] <= '0;
        tag_q[i]   <= '0;
      end
    end else if (rdy_in) begin
      if (commit_hit) begin
        value_q[commit_reg_addr] <= Commit_V;
      end
      if (control_hazard) begin
        busy_q <= '0;
        for (int i = 0; i < NUM_REGS; i++) begin
          tag_q[i] <= '0;
        end
      end else begin
        if (commit_match) begin
          busy_q[commit_reg_addr] <= 1'b0;
          tag_q[commit_reg_addr]  <= '0;
        end
        // Later assignment lets a same-register rename override the commit release.
        if (rename_hit) begin
          busy_q[rd_addr] <= 1'b1;
          tag_q[rd_addr]  <= rob_tail;
        end
      end
    end
  end

`ifdef REGFILE_BYPASS_EN
  assign fwd1 = rdy_in && !rst_in && commit_match && (commit_reg_addr == rs1_addr);
  assign fwd2 = rdy_in && !rst_in && commit_match && (commit_reg_addr == rs2_addr);
`else
  assign fwd1 = 1'b0;
  assign fwd2 = 1'b0;
`endif

  always_comb begin
    busy1 = busy_q[rs1_addr];
    Q1    = busy_q[rs1_addr] ? tag_q[rs1_addr] : '0;
    V1    = value_q[rs1_addr];
    if (rs1_addr == '0) begin
      busy1 = 1'b0;
      Q1    = '0;
      V1    = '0;
    end else if (fwd1) begin
      busy1 = 1'b0;
      Q1    = '0;
      V1    = Commit_V;
    end
  end

  always_comb begin
    busy2 = busy_q[rs2_addr];
    Q2    = busy_q[rs2_addr] ? tag_q[rs2_addr] : '0;
    V2    = value_q[rs2_addr];
    if (rs2_addr == '0) begin
      busy2 = 1'b0;
      Q2    = '0;
      V2    = '0;
    end else if (fwd2) begin
      busy2 = 1'b0;
      Q2    = '0;
      V2    = Commit_V;
    end
  end

endmodule

// File: tb/tb_reg_file.sv
// tb_reg_file: directed scenarios plus randomized issue/commit traffic checked against an array model.
// Follows the REGFILE_BYPASS_EN setting of the build for same-cycle forwarding expectations.
module tb_reg_file;
  localparam int AW = 5;
  localparam int QW = 4;
  localparam int NR = 1 << AW;

  logic          clk_in = 1'b0;
  logic          rst_in, rdy_in, control_hazard, has_issue, rename_en;
  logic [AW-1:0] rd_addr, commit_reg_addr, rs1_addr, rs2_addr;
  logic [QW-1:0] rob_tail, Commit_Q;
  logic          commit_modify_regfile;
  logic [31:0]   Commit_V;
  logic          busy1, busy2;
  logic [QW-1:0] Q1, Q2;
  logic [31:0]   V1, V2;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: architectural view of each register.
  logic [31:0]   m_val  [NR];
  logic          m_busy [NR];
  logic [QW-1:0] m_tag  [NR];

  reg_file #(.REG_ADDR_WIDTH(AW), .Q_WIDTH(QW)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .control_hazard(control_hazard),
    .has_issue(has_issue), .rd_addr(rd_addr), .rename_en(rename_en), .rob_tail(rob_tail),
    .commit_modify_regfile(commit_modify_regfile), .commit_reg_addr(commit_reg_addr),
    .Commit_Q(Commit_Q), .Commit_V(Commit_V), .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
    .busy1(busy1), .busy2(busy2), .Q1(Q1), .Q2(Q2), .V1(V1), .V2(V2)
  );

  always #5 clk_in = ~clk_in;

  // Next-state of the architectural model, applied once per rising edge.
  task automatic model_step();
    bit release_it;
    if (rst_in) begin
      for (int i = 0; i < NR; i++) begin
        m_val[i] = '0; m_busy[i] = 1'b0; m_tag[i] = '0;
      end
    end else if (rdy_in) begin
      release_it = commit_modify_regfile && commit_reg_addr != 0 && m_tag[commit_reg_addr] == Commit_Q;
      if (commit_modify_regfile && commit_reg_addr != 0) m_val[commit_reg_addr] = Commit_V;
      if (control_hazard) begin
        for (int i = 0; i < NR; i++) begin
          m_busy[i] = 1'b0; m_tag[i] = '0;
        end
      end else begin
        if (release_it) begin
          m_busy[commit_reg_addr] = 1'b0; m_tag[commit_reg_addr] = '0;
        end
        if (has_issue && rename_en && rd_addr != 0) begin
          m_busy[rd_addr] = 1'b1; m_tag[rd_addr] = rob_tail;
        end
      end
    end
  endtask

  function automatic logic [QW+32:0] exp_read(input logic [AW-1:0] a);
    logic b; logic [QW-1:0] q; logic [31:0] v;
    b = m_busy[a]; q = m_busy[a] ? m_tag[a] : '0; v = m_val[a];
    if (a == 0) begin b = 0; q = '0; v = '0; end
`ifdef REGFILE_BYPASS_EN
    if (a != 0 && rdy_in && !rst_in && commit_modify_regfile && commit_reg_addr == a &&
        m_tag[a] == Commit_Q) begin
      b = 0; q = '0; v = Commit_V;
    end
`endif
    return {b, q, v};
  endfunction

  task automatic tick();
    @(posedge clk_in);
    model_step();
    #1;
  endtask

  task automatic drive_idle();
    rst_in = 0; rdy_in = 1; control_hazard = 0; has_issue = 0; rename_en = 0;
    rd_addr = '0; rob_tail = '0; commit_modify_regfile = 0; commit_reg_addr = '0;
    Commit_Q = '0; Commit_V = '0;
  endtask

  task automatic rename(input logic [AW-1:0] rd, input logic [QW-1:0] tag);
    drive_idle();
    has_issue = 1; rename_en = 1; rd_addr = rd; rob_tail = tag;
    tick();
  endtask

  task automatic test_reset();
    drive_idle();
    rst_in = 1; rdy_in = 0; has_issue = 1; rename_en = 1; rd_addr = 5'd5; rob_tail = 4'd3;
    commit_modify_regfile = 1; commit_reg_addr = 5'd5; Commit_V = 32'hDEAD; control_hazard = 1;
    tick(); tick();
    drive_idle();
    rs1_addr = 5'd5; rs2_addr = 5'd0; #1;
    n_checks++;
    if ({busy1, Q1, V1} !== {1'b0, 4'd0, 32'd0}) begin
      n_fail++; $display("FAIL reset_x5: got busy=%0b Q=%0d V=%h want 0/0/0", busy1, Q1, V1);
    end
    for (int a = 0; a < NR; a++) begin
      rs1_addr = AW'(a); rs2_addr = AW'(NR - 1 - a); #1;
      n_checks++;
      if ({busy1, Q1, V1, busy2, Q2, V2} !== '0) begin
        n_fail++; $display("FAIL reset_sweep a=%0d: got %0b/%0d/%h %0b/%0d/%h want zeros",
                           a, busy1, Q1, V1, busy2, Q2, V2);
      end
    end
  endtask

  task automatic test_rename_commit();
    rs1_addr = 5'd3; rs2_addr = 5'd3;
    rename(5'd3, 4'd2);
    drive_idle(); #1;
    n_checks++;
    if ({busy1, Q1} !== {1'b1, 4'd2}) begin
      n_fail++; $display("FAIL rename_x3: got busy1=%0b Q1=%0d want 1/2", busy1, Q1);
    end
    commit_modify_regfile = 1; commit_reg_addr = 5'd3; Commit_Q = 4'd2; Commit_V = 32'h300;
    tick();
    drive_idle(); #1;
    n_checks++;
    if ({busy1, Q1, V1} !== {1'b0, 4'd0, 32'h300}) begin
      n_fail++; $display("FAIL commit_x3: got busy1=%0b Q1=%0d V1=%h want 0/0/300", busy1, Q1, V1);
    end
  endtask

  task automatic test_younger_rename();
    rs1_addr = 5'd3;
    rename(5'd3, 4'd2);
    rename(5'd3, 4'd5);
    drive_idle();
    commit_modify_regfile = 1; commit_reg_addr = 5'd3; Commit_Q = 4'd2; Commit_V = 32'h11;
    tick();
    drive_idle(); #1;
    n_checks++;
    if ({busy1, Q1, V1} !== {1'b1, 4'd5, 32'h11}) begin
      n_fail++; $display("FAIL younger_rename: got busy1=%0b Q1=%0d V1=%h want 1/5/11", busy1, Q1, V1);
    end
  endtask

  task automatic test_same_cycle();
    rs1_addr = 5'd4; rs2_addr = 5'd0;
    rename(5'd4, 4'd6);
    drive_idle();
    has_issue = 1; rename_en = 1; rd_addr = 5'd4; rob_tail = 4'd7;
    commit_modify_regfile = 1; commit_reg_addr = 5'd4; Commit_Q = 4'd6; Commit_V = 32'hAB;
    tick();
    drive_idle(); #1;
    n_checks++;
    if ({busy1, Q1, V1} !== {1'b1, 4'd7, 32'hAB}) begin
      n_fail++; $display("FAIL same_cycle: got busy1=%0b Q1=%0d V1=%h want 1/7/ab", busy1, Q1, V1);
    end
  endtask

  task automatic test_flush();
    rename(5'd1, 4'd1);
    rename(5'd2, 4'd2);
    rename(5'd3, 4'd3);
    drive_idle();
    rs1_addr = 5'd2; rs2_addr = 5'd3; #1;
    n_checks++;
    if ({busy1, Q1, busy2, Q2} !== {1'b1, 4'd2, 1'b1, 4'd3}) begin
      n_fail++; $display("FAIL pre_flush: got %0b/%0d %0b/%0d want 1/2 1/3", busy1, Q1, busy2, Q2);
    end
    control_hazard = 1; has_issue = 1; rename_en = 1; rd_addr = 5'd8; rob_tail = 4'd9;
    commit_modify_regfile = 1; commit_reg_addr = 5'd1; Commit_Q = 4'd1; Commit_V = 32'h55;
    tick();
    drive_idle();
    for (int a = 1; a < NR; a++) begin
      rs1_addr = AW'(a); #1;
      n_checks++;
      if ({busy1, Q1} !== {1'b0, 4'd0}) begin
        n_fail++; $display("FAIL flush_busy x%0d: got busy1=%0b Q1=%0d want 0/0", a, busy1, Q1);
      end
    end
    rs1_addr = 5'd1; #1;
    n_checks++;
    if (V1 !== 32'h55) begin
      n_fail++; $display("FAIL flush_commit_value: got V1=%h want 55", V1);
    end
  endtask

  task automatic test_bypass();
    logic [31:0] old_v;
    rs1_addr = 5'd3; rs2_addr = 5'd0;
    rename(5'd3, 4'd2);
    drive_idle();
    old_v = m_val[3];
    commit_modify_regfile = 1; commit_reg_addr = 5'd3; Commit_Q = 4'd2; Commit_V = 32'h9; #1;
    n_checks++;
`ifdef REGFILE_BYPASS_EN
    if ({busy1, Q1, V1} !== {1'b0, 4'd0, 32'h9}) begin
      n_fail++; $display("FAIL bypass_same_cycle: got busy1=%0b Q1=%0d V1=%h want 0/0/9", busy1, Q1, V1);
    end
`else
    if ({busy1, Q1, V1} !== {1'b1, 4'd2, old_v}) begin
      n_fail++; $display("FAIL nobypass_same_cycle: got busy1=%0b Q1=%0d V1=%h want 1/2/%h",
                         busy1, Q1, V1, old_v);
    end
`endif
    tick();
    drive_idle(); #1;
    n_checks++;
    if ({busy1, Q1, V1} !== {1'b0, 4'd0, 32'h9}) begin
      n_fail++; $display("FAIL bypass_next_cycle: got busy1=%0b Q1=%0d V1=%h want 0/0/9", busy1, Q1, V1);
    end
  endtask

  task automatic test_hold_and_x0();
    drive_idle();
    rdy_in = 0; has_issue = 1; rename_en = 1; rd_addr = 5'd6; rob_tail = 4'd4;
    commit_modify_regfile = 1; commit_reg_addr = 5'd7; Commit_Q = 4'd0; Commit_V = 32'h77;
    tick();
    drive_idle();
    rs1_addr = 5'd6; rs2_addr = 5'd7; #1;
    n_checks++;
    if ({busy1, Q1, V2} !== {1'b0, 4'd0, 32'd0}) begin
      n_fail++; $display("FAIL rdy_hold: got busy1=%0b Q1=%0d V2=%h want 0/0/0", busy1, Q1, V2);
    end
    has_issue = 1; rename_en = 1; rd_addr = 5'd0; rob_tail = 4'd8;
    commit_modify_regfile = 1; commit_reg_addr = 5'd0; Commit_Q = 4'd0; Commit_V = 32'hFF;
    tick();
    drive_idle();
    rs1_addr = 5'd0; #1;
    n_checks++;
    if ({busy1, Q1, V1} !== {1'b0, 4'd0, 32'd0}) begin
      n_fail++; $display("FAIL x0_write: got busy1=%0b Q1=%0d V1=%h want 0/0/0", busy1, Q1, V1);
    end
    has_issue = 1; rename_en = 0; rd_addr = 5'd9; rob_tail = 4'd3;
    tick();
    drive_idle();
    rs1_addr = 5'd9; #1;
    n_checks++;
    if (busy1 !== 1'b0) begin
      n_fail++; $display("FAIL rename_en_low: got busy1=%0b want 0", busy1);
    end
  endtask

  task automatic test_random();
    logic [QW+32:0] e1, e2;
    for (int c = 0; c < 800; c++) begin
      drive_idle();
      rst_in         = ($urandom_range(199, 0) == 0);
      rdy_in         = ($urandom_range(9, 0) != 0);
      control_hazard = ($urandom_range(29, 0) == 0);
      has_issue      = ($urandom_range(9, 0) < 6);
      rename_en      = ($urandom_range(4, 0) != 0);
      rd_addr        = AW'($urandom_range(7, 0));
      rob_tail       = QW'($urandom_range(15, 1));
      commit_modify_regfile = ($urandom_range(9, 0) < 5);
      commit_reg_addr = AW'($urandom_range(7, 0));
      Commit_Q       = $urandom_range(1, 0) ? m_tag[commit_reg_addr] : QW'($urandom_range(15, 1));
      Commit_V       = $urandom;
      rs1_addr       = $urandom_range(1, 0) ? commit_reg_addr : AW'($urandom_range(NR - 1, 0));
      rs2_addr       = $urandom_range(1, 0) ? rd_addr : AW'($urandom_range(NR - 1, 0));
      #1;
      e1 = exp_read(rs1_addr);
      e2 = exp_read(rs2_addr);
      n_checks++;
      if ({busy1, Q1, V1} !== e1) begin
        n_fail++; $display("FAIL rand_port1 c=%0d rs1=%0d: got %0b/%0d/%h want %0b/%0d/%h",
                           c, rs1_addr, busy1, Q1, V1, e1[QW+32], e1[QW+31:32], e1[31:0]);
      end
      n_checks++;
      if ({busy2, Q2, V2} !== e2) begin
        n_fail++; $display("FAIL rand_port2 c=%0d rs2=%0d: got %0b/%0d/%h want %0b/%0d/%h",
                           c, rs2_addr, busy2, Q2, V2, e2[QW+32], e2[QW+31:32], e2[31:0]);
      end
      tick();
    end
  endtask

  initial begin
    drive_idle();
    rs1_addr = '0; rs2_addr = '0;
    rst_in = 1;
    tick(); tick();
    test_reset();
    test_rename_commit();
    test_younger_rename();
    test_same_cycle();
    test_flush();
    test_bypass();
    test_hold_and_x0();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
